// File: rtl/mult_pkg.sv
// Shared types and default widths for the Booth multiplier datapath and its accumulator back end.
package mult_pkg;

    localparam int unsigned N     = 32;
    localparam int unsigned ACC_W = 72;
    localparam int unsigned LEN_W = 8;

    // Saturation limits at the default accumulator width.
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/acc_sat_adder.sv
// Combinational W-bit signed adder with overflow detect; clamps on overflow when MACC_SATURATE_EN is defined.
module acc_sat_adder #(
    parameter int unsigned W = mult_pkg::ACC_W
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] addend_i,
    output logic [W-1:0] sum_c,
    output logic         add_ovf_c
);
    import mult_pkg::*;

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] raw_sum;

    always_comb begin
        raw_sum   = acc_i + addend_i;
        // Overflow only when both operands share a sign the result does not.
        add_ovf_c = (acc_i[W-1] == addend_i[W-1]) && (raw_sum[W-1] != acc_i[W-1]);
`ifdef MACC_SATURATE_EN
        if (add_ovf_c) begin
            sum_c = acc_i[W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            sum_c = raw_sum;
        end
`else
        sum_c = raw_sum;
`endif
    end

endmodule

// File: rtl/booth_product_accumulator.sv
// MAC back end: accumulates len signed products into a wide sum with sticky overflow, valid/ready result.
// Build option: MACC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module booth_product_accumulator #(
    parameter int unsigned N     = mult_pkg::N,
    parameter int unsigned ACC_W = mult_pkg::ACC_W,
    parameter int unsigned LEN_W = mult_pkg::LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_product,
    input  logic             in_overflow,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);
    import mult_pkg::*;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               out_valid_q, out_valid_d;

    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   sum;
    logic               add_ovf;

    assign addend = ACC_W'($signed(in_product));

    acc_sat_adder #(
        .W (ACC_W)
    ) u_adder (
        .acc_i     (acc_q),
        .addend_i  (addend),
        .sum_c     (sum),
        .add_ovf_c (add_ovf)
    );

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = len;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len != '0) ? ACCUM : HOLD;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = sum;
                    ovf_d = ovf_q | in_overflow | add_ovf;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flags are registered from the next state so they track state with no input-to-output path.
        in_ready_d  = (state_d == ACCUM);
        busy_d      = (state_d == ACCUM) || (state_d == HOLD);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: doc/booth_product_accumulator.md
# booth_product_accumulator

Downstream consumer of the registered radix-4 Booth multiplier: takes the stream of signed 2N-bit products and their overflow flags, and accumulates a programmable number of them into a wide signed sum. The block is a multiply-accumulate (MAC) back end for dot-product style workloads. It reports the finished sum through a valid/ready output handshake. The sum carries a sticky overflow indication.

## Interface
- N, 32, operand width of the upstream multiplier; products are 2N bits
- ACC_W, 72, accumulator width; must be ≥ 2N
- LEN_W, 8, width of the product-count field
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, no other clock domains
- start  input  1  begin a new accumulation; sampled only in IDLE
- len  input  LEN_W  number of products to accumulate, captured with start
- in_valid  input  1  in_product/in_overflow valid this cycle
- in_ready  output  1  block accepts a product this cycle
- in_product  input  2N  signed two's-complement product from the multiplier
- in_overflow  input  1  upstream overflow flag for this product
- busy  output  1  high in ACCUM and HOLD
- out_valid  output  1  out_acc/out_ovf hold a finished result
- out_ready  input  1  downstream accepts the result
- out_acc  output  ACC_W  signed accumulated sum
- out_ovf  output  1  sticky: any upstream overflow or any accumulator overflow in this run

## Operation
- States:
  - IDLE: in_ready=0, out_valid=0.
  - ACCUM: in_ready=1.
  - HOLD: out_valid=1, in_ready=0.
- IDLE, start=1:
  - capture len into the remaining counter, clear acc and ovf;
  - go to ACCUM if len≠0, else go to HOLD with acc=0, ovf=0.
- IDLE, start=0: stay in IDLE.
- ACCUM, per accepted beat (in_valid & in_ready):
  - acc ← acc + sign_extend(in_product, ACC_W);
  - ovf ← ovf | in_overflow | add_ovf, where add_ovf = signed overflow of the ACC_W-bit add;
  - remaining decrements; on the beat where remaining==1, go to HOLD.
- ACCUM, in_valid=0: no change. Bubbles are allowed without limit.
- HOLD: out_acc/out_ovf stable while out_valid & !out_ready. On out_ready, go to IDLE.
- start is ignored outside IDLE. in_valid is ignored outside ACCUM; those beats are dropped and it is upstream's job to respect in_ready.
- reset in any state: state=IDLE, acc=0, ovf=0, remaining=0; any partial run is discarded.

## Timing
- Reset values: in_ready=0, busy=0, out_valid=0, out_acc=0, out_ovf=0.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- start→busy: 1 cycle.
- Last accepted beat at cycle t → out_valid high at t+1, with out_acc including that beat.
- out_valid & out_ready at t → IDLE at t+1. A start at t+1 is accepted, so back-to-back runs cost one idle cycle.
- len=0: start at t → out_valid at t+1, out_acc=0.
- Maximum run length: 2^LEN_W−1 products; throughput 1 product/cycle.

## Configuration
- MACC_SATURATE_EN defined:
  - on add_ovf, acc clamps to signed max (0x7F…F) for positive overflow or signed min (0x80…0) for negative overflow;
  - later beats continue from the clamped value.
- MACC_SATURATE_EN undefined: acc wraps modulo 2^ACC_W.
- out_ovf behaves identically in both builds.

## Structure
- Shared package mult_pkg holds:
  - state enum {IDLE, ACCUM, HOLD};
  - default widths N, ACC_W, LEN_W;
  - ACC_MAX/ACC_MIN constants used for saturation.
- One sub-module: acc_sat_adder.
  - Inputs: ACC_W accumulator, sign-extended addend.
  - Outputs: sum (saturated under MACC_SATURATE_EN) and add_ovf.
  - Purely combinational; the FSM, counter and output registers stay in the top module.

## Test plan
- Basic run: start with len=3, feed products 5, −2, 10 with out_ready=1 → out_valid one cycle after the third beat, out_acc=13, out_ovf=0, back to IDLE the next cycle.
- Bubbles and backpressure: len=2 with 3 idle cycles between the beats, out_ready=0 for 4 cycles → out_acc=sum, held stable every stalled cycle, single completion on out_ready.
- Upstream overflow: len=2, second beat carries in_overflow=1 → out_ovf=1, and out_acc is still the exact sum.
- Accumulator overflow with ACC_W=2N=64: add 0x7FFF_FFFF_FFFF_FFFF then 1.
  - Wrap build: out_acc=0x8000_0000_0000_0000.
  - MACC_SATURATE_EN build: out_acc=0x7FFF_FFFF_FFFF_FFFF.
  - Both builds: out_ovf=1.
- Edge cases: len=0 → out_acc=0 one cycle after start. start asserted during ACCUM is ignored. in_valid during HOLD does not change out_acc.
- Reset mid-run: assert reset after 2 of 5 beats → all outputs 0 next cycle. A new start with len=1, product 7 → out_acc=7.
